// File: rtl/debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module      : debounce_fsm
// Description : Push-button debouncer. Synchronises the raw level and accepts
//               a change only after STABLE_TICKS consecutive stable ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_fsm #(
    parameter int STABLE_TICKS = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic tick,
    output logic db_out,
    output logic rise,
    output logic fall
);

    localparam int c_CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {
        LOW     = 2'b00,
        WAIT_HI = 2'b01,
        HIGH    = 2'b10,
        WAIT_LO = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_db;
    logic                   r_rise;
    logic                   r_fall;

    state_t                 w_state_next;
    logic [c_CNT_W-1:0]     w_cnt_next;
    logic                   w_db_next;
    logic                   w_rise_next;
    logic                   w_fall_next;
    logic                   w_btn_s;

    assign w_btn_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_state <= LOW;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], btn_in};
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_db    <= w_db_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
        end
    end

    // A level reversal during a wait aborts it even when a tick lands on the
    // same cycle, so the reversal checks come before the tick checks.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rise_next  = 1'b0;
        w_fall_next  = 1'b0;
        case (r_state)
            LOW: begin
                if (w_btn_s) begin
                    w_state_next = WAIT_HI;
                    w_cnt_next   = '0;
                end
            end
            WAIT_HI: begin
                if (!w_btn_s) begin
                    w_state_next = LOW;
                    w_cnt_next   = '0;
                end else if (tick) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_next = HIGH;
                        w_cnt_next   = '0;
                        w_rise_next  = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            HIGH: begin
                if (!w_btn_s) begin
                    w_state_next = WAIT_LO;
                    w_cnt_next   = '0;
                end
            end
            WAIT_LO: begin
                if (w_btn_s) begin
                    w_state_next = HIGH;
                    w_cnt_next   = '0;
                end else if (tick) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_next = LOW;
                        w_cnt_next   = '0;
                        w_fall_next  = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = LOW;
                w_cnt_next   = '0;
            end
        endcase
        w_db_next = (w_state_next == HIGH) || (w_state_next == WAIT_LO);
    end

    assign db_out = r_db;
    assign rise   = r_rise;
    assign fall   = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_fsm
// Description : Scoreboard bench for debounce_fsm; expected pulses are queued
//               by the stimulus and retired by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_fsm;

    logic clk;
    logic reset;
    logic btn_in;
    logic tick;
    logic db_out;
    logic rise;
    logic fall;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic auto_tick;
    logic auto_val;
    logic man_tick;

    typedef struct {
        bit is_rise;
        int ref_cyc;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];

    debounce_fsm #(
        .STABLE_TICKS(4),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn_in(btn_in),
        .tick  (tick),
        .db_out(db_out),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub timer: the tick is seen by the posedge that makes cyc a multiple of 10.
    always @(negedge clk) auto_val = ((cyc + 1) % 10 == 0);
    assign tick = auto_tick ? auto_val : man_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: retires one expected event per observed pulse.
    logic prev_pulse = 1'b0;
    exp_t mon_e;
    int   mon_lat;
    always @(negedge clk) begin
        if (rise && fall) check("rise_fall_together", 1, 0);
        if (reset && (rise || fall)) check("pulse_in_reset", 1, 0);
        if (rise || fall) begin
            if (prev_pulse) check("pulse_width", 2, 1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: rise=%0b fall=%0b at cycle %0d, none expected",
                         rise, fall, cyc);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_lat = cyc - mon_e.ref_cyc;
                check("pulse_kind_rise", {31'd0, rise}, {31'd0, mon_e.is_rise});
                check("pulse_db_level", {31'd0, db_out}, {31'd0, mon_e.is_rise});
                n_cmp++;
                if (mon_lat < mon_e.lo || mon_lat > mon_e.hi) begin
                    n_err++;
                    $display("FAIL pulse_latency: got %0d cycles expected %0d..%0d",
                             mon_lat, mon_e.lo, mon_e.hi);
                end
            end
        end
        prev_pulse = rise || fall;
    end

    task automatic align10();
        @(negedge clk);
        while (cyc % 10 != 0) @(negedge clk);
    endtask

    task automatic expect_pulse(input bit is_rise, input int lo, input int hi);
        exp_t e;
        e.is_rise = is_rise;
        e.ref_cyc = cyc;
        e.lo      = lo;
        e.hi      = hi;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check(name, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        btn_in    = 1'b1;
        auto_tick = 1'b1;
        man_tick  = 1'b0;

        // 1: reset held with the button pressed, then release
        repeat (5) begin
            @(negedge clk);
            check("reset_outputs", {29'd0, db_out, rise, fall}, 32'd0);
        end
        align10();
        reset = 1'b0;
        expect_pulse(1'b1, 1, 44);
        wait_drain("t1_rise_timeout", 60);
        check("t1_db_high", {31'd0, db_out}, 32'd1);

        // 4: release from HIGH
        align10();
        btn_in = 1'b0;
        expect_pulse(1'b0, 35, 44);
        wait_drain("t4_fall_timeout", 60);
        check("t4_db_low", {31'd0, db_out}, 32'd0);

        // 2: clean press held 100 cycles
        align10();
        btn_in = 1'b1;
        expect_pulse(1'b1, 35, 44);
        repeat (30) @(negedge clk);
        check("t2_db_not_early", {31'd0, db_out}, 32'd0);
        repeat (70) @(negedge clk);
        wait_drain("t2_rise_timeout", 10);
        check("t2_db_high", {31'd0, db_out}, 32'd1);

        // 4 again: return to LOW before the bounce test
        align10();
        btn_in = 1'b0;
        expect_pulse(1'b0, 35, 44);
        wait_drain("t4b_fall_timeout", 60);

        // 3: bounce every 3 cycles for 60 cycles, settle low
        for (int i = 0; i < 20; i++) begin
            btn_in = ~btn_in;
            repeat (3) @(negedge clk);
            check("t3_db_during_bounce", {31'd0, db_out}, 32'd0);
        end
        btn_in = 1'b0;
        repeat (50) @(negedge clk);
        check("t3_db_settled", {31'd0, db_out}, 32'd0);

        // 5: abort on the same cycle as the acceptance tick (cnt==3)
        align10();
        auto_tick = 1'b0;
        man_tick  = 1'b1;
        btn_in    = 1'b1;
        repeat (4) @(negedge clk);
        btn_in = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_db_waiting", {31'd0, db_out}, 32'd0);
        @(negedge clk);
        man_tick = 1'b0;
        check("t5_abort", {30'd0, db_out, rise}, 32'd0);
        auto_tick = 1'b1;
        repeat (50) @(negedge clk);
        check("t5_db_after", {31'd0, db_out}, 32'd0);

        // 6: reset mid-wait with cnt==2
        align10();
        auto_tick = 1'b0;
        man_tick  = 1'b0;
        btn_in    = 1'b1;
        repeat (3) @(negedge clk);
        man_tick = 1'b1;
        repeat (2) @(negedge clk);
        man_tick = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        btn_in = 1'b0;
        #1;
        check("t6_reset_async", {29'd0, db_out, rise, fall}, 32'd0);
        repeat (3) @(negedge clk);
        check("t6_reset_hold", {29'd0, db_out, rise, fall}, 32'd0);
        reset     = 1'b0;
        auto_tick = 1'b1;
        repeat (60) @(negedge clk);
        check("t6_db_after", {31'd0, db_out}, 32'd0);

        // a fresh press must still need the full four ticks
        align10();
        btn_in = 1'b1;
        expect_pulse(1'b1, 35, 44);
        wait_drain("t6_press_timeout", 60);
        check("t6_db_high", {31'd0, db_out}, 32'd1);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
